// File: rtl/imem_responder.sv
// Instruction memory responder: word array with a fixed-latency fetch pipeline.
// Supports wait-state injection (stall) and preloading of the backing array.
module imem_responder #(
  parameter int                 DATA_W    = 64,
  parameter int                 ADDR_W    = 64,
  parameter int                 DEPTH     = 256,
  parameter int                 LATENCY   = 1,
  parameter logic [DATA_W-1:0]  FILL_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_addr_valid,
  output logic [DATA_W-1:0]        imem_data,
  output logic                     imem_data_valid,
  input  logic                     stall,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     oor_err,
  output logic [31:0]              req_count
);

  localparam int IW  = $clog2(DEPTH);
  localparam int OFS = $clog2(DATA_W / 8);

  // Contents start as the fill word; reset never touches them.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_WORD};

  logic [ADDR_W-1:0] word_idx;
  logic              req_oor;
  logic              accept;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] fetch_word;

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] po;
  logic [DATA_W-1:0]  pd [LATENCY];

  logic [DATA_W-1:0] disp_word;
  logic [DATA_W-1:0] hold_q;

  assign word_idx = imem_addr >> OFS;
  assign req_oor  = (word_idx >= ADDR_W'(DEPTH));
  assign accept   = imem_addr_valid & ~stall & ~rst;

  // Write-first read: a same-cycle load to the fetched index wins.
  always_comb begin
    rd_word = mem[word_idx[IW-1:0]];
    if (load_en && (load_idx == word_idx[IW-1:0]))
      rd_word = load_data;
    fetch_word = req_oor ? FILL_WORD : rd_word;
  end

  // Backing array write port, independent of stall and reset.
  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_idx] <= load_data;
  end

  // Valid/oor shift pipeline; frozen on stall, flushed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      po <= '0;
    end else if (!stall) begin
      pv[0] <= accept;
      po[0] <= req_oor;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
    end
  end

  // Data pipeline; contents only matter where the matching valid is set.
  always_ff @(posedge clk) begin
    if (!stall) begin
      pd[0] <= fetch_word;
      for (int i = 1; i < LATENCY; i++)
        pd[i] <= pd[i-1];
    end
  end

  // Last presented word, replayed on the bus while stalled.
  always_ff @(posedge clk) begin
    if (rst)
      hold_q <= '0;
    else if (!stall)
      hold_q <= disp_word;
  end

  // Saturating count of accepted requests.
  always_ff @(posedge clk) begin
    if (rst)
      req_count <= '0;
    else if (accept && (req_count != 32'hFFFF_FFFF))
      req_count <= req_count + 32'd1;
  end

  // Output drive: idle bus is zero, stalled bus holds its last word.
  always_comb begin
    disp_word       = pv[LATENCY-1] ? pd[LATENCY-1] : '0;
    imem_data       = stall ? hold_q : disp_word;
    imem_data_valid = pv[LATENCY-1] & ~stall;
    oor_err         = pv[LATENCY-1] & po[LATENCY-1] & ~stall;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: queue-based reference model plus directed
// literal checks, followed by a randomized phase.
module tb_imem_responder;

  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int DEPTH = 256;
  localparam int L     = 3;
  localparam logic [63:0] FILL = 64'hA5A5_0000_0000_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic [63:0] imem_data;
  logic        imem_data_valid;
  logic        stall;
  logic        load_en;
  logic [7:0]  load_idx;
  logic [63:0] load_data;
  logic        oor_err;
  logic [31:0] req_count;

  always #5 clk = ~clk;

  imem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .LATENCY(L), .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .stall(stall), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .oor_err(oor_err), .req_count(req_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: in-flight requests with their unstalled age.
  typedef struct {
    int          age;
    logic [63:0] d;
    bit          oor;
  } ent_t;

  ent_t        q[$];
  ent_t        nq[$];
  logic [63:0] mm [DEPTH];
  logic [63:0] hold = '0;
  logic [31:0] cnt = '0;
  bit          live = 0;

  initial for (int i = 0; i < DEPTH; i++) mm[i] = FILL;

  function automatic void exp_out(output bit v, output logic [63:0] d,
                                  output bit o);
    v = 0; d = '0; o = 0;
    foreach (q[i])
      if (q[i].age == L) begin
        v = 1; d = q[i].d; o = q[i].oor;
      end
    if (stall) begin
      v = 0; o = 0; d = hold;
    end
  endfunction

  always @(posedge clk) begin
    bit          v, o, roor;
    logic [63:0] d, rd;
    exp_out(v, d, o);
    if (load_en) mm[load_idx] = load_data;
    if (rst) begin
      q.delete();
      cnt  = '0;
      hold = '0;
    end else if (!stall) begin
      hold = d;
      nq = {};
      foreach (q[i])
        if (q[i].age < L) nq.push_back('{q[i].age + 1, q[i].d, q[i].oor});
      q = nq;
      if (imem_addr_valid) begin
        roor = (imem_addr >> 3) >= 64'(DEPTH);
        rd   = roor ? FILL : mm[imem_addr[10:3]];
        q.push_back('{1, rd, roor});
        if (cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    bit          v, o;
    logic [63:0] d;
    if (live) begin
      exp_out(v, d, o);
      chk("m_valid", 64'(imem_data_valid), 64'(v));
      chk("m_data", imem_data, d);
      chk("m_oor", 64'(oor_err), 64'(o));
      chk("m_count", 64'(req_count), 64'(cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_addr_valid = 0; imem_addr = '0; stall = 0;
    load_en = 0; load_idx = '0; load_data = '0;
  endtask

  task automatic req(logic [63:0] a);
    imem_addr_valid = 1; imem_addr = a;
  endtask

  int          pulses;
  logic [31:0] c0;

  initial begin
    idle();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    live = 1;
    @(negedge clk);
    chk("rst_valid", 64'(imem_data_valid), 64'd0);
    chk("rst_data", imem_data, 64'd0);
    chk("rst_count", 64'(req_count), 64'd0);

    // Streaming fetches of address 0.
    for (int i = 0; i < 8; i++) begin req(64'h0); tick(); end
    idle();
    @(negedge clk);
    chk("stream_cnt", 64'(req_count), 64'd8);
    repeat (L + 1) tick();

    // Preloaded word returned after exactly L cycles.
    load_en = 1; load_idx = 8'd5; load_data = 64'hDEAD_BEEF_0000_0001;
    tick(); idle();
    req(64'h28); tick(); idle();
    @(negedge clk);
    chk("lat_early", 64'(imem_data_valid), 64'd0);
    repeat (L - 1) tick();
    @(negedge clk);
    chk("lat_valid", 64'(imem_data_valid), 64'd1);
    chk("lat_data", imem_data, 64'hDEAD_BEEF_0000_0001);
    chk("lat_oor", 64'(oor_err), 64'd0);
    repeat (L) tick();

    // Range boundary: index 256 is out, index 255 is stored.
    load_en = 1; load_idx = 8'd255; load_data = 64'h7777_0000_0000_00FF;
    tick(); idle();
    req(64'h800); tick();
    req(64'h7F8); tick(); idle();
    repeat (L - 2) tick();
    @(negedge clk);
    chk("oor_data", imem_data, FILL);
    chk("oor_flag", 64'(oor_err), 64'd1);
    tick();
    @(negedge clk);
    chk("last_data", imem_data, 64'h7777_0000_0000_00FF);
    chk("last_oor", 64'(oor_err), 64'd0);
    repeat (L) tick();

    // Write-first on a same-cycle load.
    load_en = 1; load_idx = 8'd2; load_data = 64'h1234;
    req(64'h10); tick(); idle();
    repeat (L - 1) tick();
    @(negedge clk);
    chk("wf_data", imem_data, 64'h1234);
    repeat (L) tick();

    // Stall drops the concurrent request and delays the earlier one.
    c0 = req_count;
    req(64'h28); tick();
    req(64'h10); stall = 1; tick();
    repeat (3) tick();
    idle();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_data_valid) pulses++;
      tick();
    end
    chk("stall_pulses", 64'(pulses), 64'd1);
    chk("stall_cnt", 64'(req_count), 64'(c0 + 32'd1));

    // Reset with requests in flight discards them.
    req(64'h0); tick(); tick(); tick();
    idle(); rst = 1; tick(); rst = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_data_valid) pulses++;
      tick();
    end
    chk("rst_pulses", 64'(pulses), 64'd0);
    chk("rst_cnt0", 64'(req_count), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8)
        imem_addr = {53'd0, 8'($urandom_range(0, 255)), 3'($urandom)};
      else if (r == 8)
        imem_addr = {32'($urandom), 32'($urandom)};
      else
        imem_addr = 64'h800 + 64'($urandom_range(0, 64));
      imem_addr_valid = ($urandom_range(0, 9) < 7);
      stall           = ($urandom_range(0, 9) < 2);
      load_en         = ($urandom_range(0, 9) < 3);
      load_idx        = ($urandom_range(0, 1) == 0) ?
                        imem_addr[10:3] : 8'($urandom);
      load_data       = {32'($urandom), 32'($urandom)};
      rst             = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle(); rst = 0;
    repeat (L + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
